// File: rtl/systolic_result_drain.sv
// ============================================================================
// Module      : systolic_result_drain
// Description : Captures a finished systolic result tile on the rising edge of
//               calc_done_flag and streams it out one row per valid/ready beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_result_drain #(
    parameter  int WIDTH      = 16,
    parameter  int ARR_HEIGHT = 4,
    parameter  int ARR_WIDTH  = 4,
    localparam int IDX_W      = (ARR_HEIGHT > 1) ? $clog2(ARR_HEIGHT) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  calc_done_flag,
    input  logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] out_c,
    output logic [ARR_WIDTH*WIDTH-1:0]            out_row_data,
    output logic [IDX_W-1:0]                      out_row_idx,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  overrun,
    output logic [15:0]                           tile_count
);

    localparam int               c_ROW_W    = ARR_WIDTH * WIDTH;
    localparam logic [IDX_W-1:0] c_LAST_ROW = IDX_W'(ARR_HEIGHT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                                r_state;
    state_t                                w_state_nxt;
    logic                                  r_done_q;
    logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] r_snap;
    logic [IDX_W-1:0]                      r_row;
    logic                                  r_overrun;
    logic [15:0]                           r_tile_count;

    logic                                  w_rise;
    logic                                  w_xfer;
    logic                                  w_at_last;
    logic [c_ROW_W-1:0]                    w_rows [ARR_HEIGHT];

    assign w_rise    = calc_done_flag & ~r_done_q;
    assign w_xfer    = (r_state == ST_DRAIN) & out_ready;
    assign w_at_last = (r_row == c_LAST_ROW);

    generate
        for (genvar r = 0; r < ARR_HEIGHT; r++) begin : g_rows
            assign w_rows[r] = r_snap[r*c_ROW_W +: c_ROW_W];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_rise) w_state_nxt = ST_DRAIN;
            // A rise coinciding with the last transfer chains straight into the next tile
            ST_DRAIN: if (w_xfer && w_at_last && !w_rise) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_done_q     <= 1'b0;
            r_snap       <= '0;
            r_row        <= '0;
            r_overrun    <= 1'b0;
            r_tile_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_done_q <= calc_done_flag;
            if (r_state == ST_IDLE) begin
                if (w_rise) begin
                    r_snap <= out_c;
                    r_row  <= '0;
                end
            end else begin
                if (w_xfer) begin
                    if (w_at_last) begin
                        r_tile_count <= r_tile_count + 16'd1;
                        r_row        <= '0;
                        if (w_rise) r_snap <= out_c;
                    end else begin
                        r_row <= r_row + IDX_W'(1);
                    end
                end
                // Tile arriving mid-drain has nowhere to go
                if (w_rise && !(w_xfer && w_at_last)) r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid    = (r_state == ST_DRAIN);
    assign busy         = (r_state == ST_DRAIN);
    assign out_row_data = w_rows[r_row];
    assign out_row_idx  = r_row;
    assign out_last     = (r_state == ST_DRAIN) & w_at_last;
    assign overrun      = r_overrun;
    assign tile_count   = r_tile_count;

endmodule

`default_nettype wire
